vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//   Produces VGA raster timing: pixel coordinates hc/vc, active-video valid, hsync and vsync.
//   Sits upstream of the colour/pixel stage, which consumes hc, vc and valid to fetch image
//   data. Also provides frame/line strobes and a frame counter for game-logic pacing.
// PARAMETERS
//   H_ACTIVE 640  visible pixels per line
//   H_FP     16   horizontal front porch (pixels)
//   H_SYNC   96   hsync pulse width (pixels)
//   H_BP     48   horizontal back porch (pixels); H_TOTAL = sum of the four = 800
//   V_ACTIVE 480  visible lines per frame
//   V_FP     10   vertical front porch (lines)
//   V_SYNC   2    vsync pulse width (lines)
//   V_BP     33   vertical back porch (lines); V_TOTAL = sum of the four = 525
//   SYNC_POL 0    sync asserted level (0 = active-low, the 640x480@60 standard)
// PORTS
//   clk_25m     in   1   pixel clock, 25 MHz, rising edge
//   rst         in   1   asynchronous, active-high reset
//   ce          in   1   clock enable; all state holds when 0
//   hc          out  10  horizontal count, 0..H_TOTAL-1
//   vc          out  10  vertical count, 0..V_TOTAL-1
//   valid       out  1   1 when hc<H_ACTIVE and vc<V_ACTIVE
//   hsync       out  1   horizontal sync, SYNC_POL level inside pulse window
//   vsync       out  1   vertical sync, SYNC_POL level inside pulse window
//   line_end    out  1   1-cycle strobe when hc==H_TOTAL-1
//   frame_start out  1   1-cycle strobe when hc==0 and vc==0
//   frame_cnt   out  16  completed-frame counter
// BEHAVIOUR
//   - All outputs are registers. rst asserted: hc=0, vc=0, valid=0, hsync=vsync=~SYNC_POL,
//     line_end=0, frame_start=0, frame_cnt=0, state=IDLE. Applies immediately, mid-frame too.
//   - States: IDLE -> RUN. IDLE: first edge with ce=1 keeps hc=vc=0 and loads decodes for
//     (0,0): valid=1, frame_start=1, sync inactive; state->RUN. RUN stays until rst.
//   - RUN, ce=1: hc<=hc+1; at hc==H_TOTAL-1, hc<=0 and vc<=vc+1; at vc==V_TOTAL-1 with
//     hc wrap, vc<=0 and frame_cnt<=frame_cnt+1 (16-bit wrap 0xFFFF->0x0000).
//   - valid/hsync/vsync/line_end/frame_start are decoded from the NEXT hc/vc and registered
//     on the same edge, so on every cycle they describe the hc/vc presented that cycle.
//   - hsync window: H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751 default).
//   - vsync window: V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491), independent of hc.
//   - ce=0: counters, sync, valid and frame_cnt hold; line_end and frame_start forced 0.
//   - Simultaneous line/frame wrap: line_end=1 on hc=799,vc=524; next cycle frame_start=1,
//     frame_cnt already incremented.
//   - Counter widths fixed at 10 bits; parameters must give H_TOTAL, V_TOTAL <= 1024.
// CONFIGURATION
//   VGA_SYNC_DELAY_EN defined: hsync and vsync pass through one extra register stage, so
//     they lag hc/vc/valid by exactly 1 clock, matching the registered colour output of the
//     pixel stage; the extra stage resets to ~SYNC_POL and holds when ce=0.
//   Not defined: hsync/vsync are cycle-aligned with hc/vc/valid (0 extra latency).
// TESTING
//   1. rst=1 then released, ce=1 -> 1st edge hc=0,vc=0,valid=1,frame_start=1; 2nd edge hc=1.
//   2. Run 800 cycles -> hc 799->0, vc 0->1, line_end=1 only at hc=799; valid=0 at hc>=640.
//   3. Full frame (420000 cycles) -> hsync low exactly for hc 656..751 each line; vsync low
//      for vc 490..491; frame_cnt 0->1 coincident with frame_start at (0,0).
//   4. ce toggled 1/0 every cycle -> counters advance every other cycle; strobes never
//      high while ce=0; a full frame takes 840000 cycles.
//   5. rst pulsed at hc=300,vc=200 -> outputs return to reset values asynchronously,
//      before next edge; restart per scenario 1; frame_cnt=0.
//   6. VGA_SYNC_DELAY_EN defined -> hsync first low on the cycle where hc==657; vsync
//      delayed likewise; without macro hsync first low at hc==656.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Raster-timing bundle between the VGA sync generator (master) and the pixel stage (slave).
// The master drives coordinates, decodes and strobes; the slave supplies the clock enable.
interface vga_sync_gen_if;
  logic        ce;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        valid;
  logic        hsync;
  logic        vsync;
  logic        line_end;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    input  ce,
    output hc, vc, valid, hsync, vsync, line_end, frame_start, frame_cnt
  );

  modport slave (
    output ce,
    input  hc, vc, valid, hsync, vsync, line_end, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel coordinates, active-video valid, sync pulses and strobes.
// Optional macro VGA_SYNC_DELAY_EN adds one register stage on hsync/vsync.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk_25m,
  input  logic              rst,
  vga_sync_gen_if.master    bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HC_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA_END  = 10'(H_ACTIVE);
  localparam logic [9:0] VA_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_hc, r_vc, w_hc_nxt, w_vc_nxt;
  logic [15:0] r_fcnt, w_fcnt_nxt;
  logic        r_valid, r_hs, r_vs, r_le, r_fs;
  logic        w_valid_nxt, w_hs_nxt, w_vs_nxt, w_le_nxt, w_fs_nxt;

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next coordinates, then decodes taken from those next coordinates so that the
  // registered flags always describe the hc/vc presented in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc;
    w_vc_nxt    = r_vc;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      IDLE: begin
        if (bus.ce) begin
          w_state_nxt = RUN;
          w_hc_nxt    = '0;
          w_vc_nxt    = '0;
        end
      end
      RUN: begin
        if (bus.ce) begin
          if (r_hc == HC_LAST) begin
            w_hc_nxt = '0;
            if (r_vc == VC_LAST) begin
              w_vc_nxt   = '0;
              w_fcnt_nxt = r_fcnt + 16'd1;
            end else begin
              w_vc_nxt = r_vc + 10'd1;
            end
          end else begin
            w_hc_nxt = r_hc + 10'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_valid_nxt = (w_hc_nxt < HA_END) && (w_vc_nxt < VA_END);
    w_hs_nxt    = ((w_hc_nxt >= HS_BEG) && (w_hc_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_vs_nxt    = ((w_vc_nxt >= VS_BEG) && (w_vc_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    w_le_nxt    = bus.ce && (w_hc_nxt == HC_LAST);
    w_fs_nxt    = bus.ce && (w_hc_nxt == 10'd0) && (w_vc_nxt == 10'd0);
  end

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_hc    <= '0;
      r_vc    <= '0;
      r_fcnt  <= '0;
      r_valid <= 1'b0;
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_le    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_le <= w_le_nxt;
      r_fs <= w_fs_nxt;
      if (bus.ce) begin
        r_hc    <= w_hc_nxt;
        r_vc    <= w_vc_nxt;
        r_fcnt  <= w_fcnt_nxt;
        r_valid <= w_valid_nxt;
        r_hs    <= w_hs_nxt;
        r_vs    <= w_vs_nxt;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Extra sync stage lines the pulses up with the pixel stage's registered colour output.
  logic r_hs_d, r_vs_d;

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_hs_d <= ~SYNC_POL;
      r_vs_d <= ~SYNC_POL;
    end else if (bus.ce) begin
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
    end
  end

  assign bus.hsync = r_hs_d;
  assign bus.vsync = r_vs_d;
`else
  assign bus.hsync = r_hs;
  assign bus.vsync = r_vs;
`endif

  assign bus.hc          = r_hc;
  assign bus.vc          = r_vc;
  assign bus.valid       = r_valid;
  assign bus.line_end    = r_le;
  assign bus.frame_start = r_fs;
  assign bus.frame_cnt   = r_fcnt;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a small-raster instance share clk/rst/ce;
// both are checked every cycle against a position-based raster model plus literal expectations.
module tb_vga_sync_gen;
  logic clk_25m = 1'b0;
  logic rst;
  logic ce;

  always #20 clk_25m = ~clk_25m;

  vga_sync_gen_if if_d ();
  vga_sync_gen_if if_s ();
  assign if_d.ce = ce;
  assign if_s.ce = ce;

  vga_sync_gen dut_d (
    .clk_25m (clk_25m),
    .rst     (rst),
    .bus     (if_d)
  );

  // Small raster: H 16+4+6+4 = 30, V 8+2+2+3 = 15, so a frame is 450 enabled cycles.
  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0)
  ) dut_s (
    .clk_25m (clk_25m),
    .rst     (rst),
    .bus     (if_s)
  );

  typedef struct {
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        valid;
    logic        hsync;
    logic        vsync;
    logic        le;
    logic        fs;
    logic [15:0] fc;
  } vo_t;

  // Model state: number of enabled edges since reset, and whether the latest edge was enabled.
  longint n_ce;
  bit     last_ce;

  always @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      n_ce    <= 0;
      last_ce <= 1'b0;
    end else begin
      last_ce <= ce;
      if (ce) n_ce <= n_ce + 1;
    end
  end

  // The n-th enabled edge presents raster position n-1 (the first one only leaves IDLE at (0,0)).
  function automatic vo_t model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                input longint n, input bit lst);
    vo_t    o;
    longint ht, vt, p, q;
    int     h, v, hq, vq;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    o = '{10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    if (n == 0) return o;
    p = n - 1;
    h = int'(p % ht);
    v = int'((p / ht) % vt);
    o.hc    = 10'(h);
    o.vc    = 10'(v);
    o.fc    = 16'((p / (ht * vt)) % 65536);
    o.valid = (h < ha) && (v < va);
`ifdef VGA_SYNC_DELAY_EN
    q = n - 2;
`else
    q = n - 1;
`endif
    if (q >= 0) begin
      hq = int'(q % ht);
      vq = int'((q / ht) % vt);
      o.hsync = !((hq >= ha + hf) && (hq < ha + hf + hs));
      o.vsync = !((vq >= va + vf) && (vq < va + vf + vs));
    end
    o.le = lst && (h == ht - 1);
    o.fs = lst && (h == 0) && (v == 0);
    return o;
  endfunction

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_vo(input string tag, input vo_t a, input vo_t e);
    chk({tag, ".hc"},          a.hc,    e.hc);
    chk({tag, ".vc"},          a.vc,    e.vc);
    chk({tag, ".valid"},       a.valid, e.valid);
    chk({tag, ".hsync"},       a.hsync, e.hsync);
    chk({tag, ".vsync"},       a.vsync, e.vsync);
    chk({tag, ".line_end"},    a.le,    e.le);
    chk({tag, ".frame_start"}, a.fs,    e.fs);
    chk({tag, ".frame_cnt"},   a.fc,    e.fc);
  endtask

  task automatic compare_all();
    vo_t a;
    a = '{if_d.hc, if_d.vc, if_d.valid, if_d.hsync, if_d.vsync,
          if_d.line_end, if_d.frame_start, if_d.frame_cnt};
    cmp_vo("d", a, model(640, 16, 96, 48, 480, 10, 2, 33, n_ce, last_ce));
    a = '{if_s.hc, if_s.vc, if_s.valid, if_s.hsync, if_s.vsync,
          if_s.line_end, if_s.frame_start, if_s.frame_cnt};
    cmp_vo("s", a, model(16, 4, 6, 4, 8, 2, 2, 3, n_ce, last_ce));
  endtask

  // Inputs change just after a falling edge; outputs are compared on the falling edge.
  task automatic step(input bit v);
    ce = v;
    @(posedge clk_25m);
    @(negedge clk_25m);
    compare_all();
  endtask

  initial begin
    int  k;
    bit  seen;
    int  hs_first, exp_hs_first;
    int  ph, pv, ple, h0, v0, vs_low;

    rst = 1'b1;
    ce  = 1'b0;
    repeat (3) @(negedge clk_25m);
    compare_all();
    chk("rst_hsync", if_d.hsync, 1);
    chk("rst_valid", if_d.valid, 0);
    rst = 1'b0;
    step(1'b0);
    chk("idle_hold_valid", if_d.valid, 0);

    // Leaving IDLE: (0,0) with its decodes, then counting starts.
    step(1'b1);
    chk("first_hc", if_d.hc, 0);
    chk("first_vc", if_d.vc, 0);
    chk("first_valid", if_d.valid, 1);
    chk("first_frame_start", if_d.frame_start, 1);
    step(1'b1);
    chk("second_hc", if_d.hc, 1);
    chk("second_frame_start", if_d.frame_start, 0);

    // First line on the default raster.
    seen = 1'b0;
    hs_first = -1;
    k = 0;
    while (if_d.hc != 10'd799 && k < 900) begin
      step(1'b1);
      if (!seen && if_d.hsync == 1'b0) begin
        seen = 1'b1;
        hs_first = int'(if_d.hc);
      end
      k++;
    end
    chk("reach_hc799", k < 900, 1);
`ifdef VGA_SYNC_DELAY_EN
    exp_hs_first = 657;
`else
    exp_hs_first = 656;
`endif
    chk("hsync_first_low_hc", hs_first, exp_hs_first);
    chk("line_end_at_799", if_d.line_end, 1);
    chk("valid_at_799", if_d.valid, 0);
    chk("vc_at_799", if_d.vc, 0);
    step(1'b1);
    chk("wrap_hc", if_d.hc, 0);
    chk("wrap_vc", if_d.vc, 1);
    chk("wrap_line_end", if_d.line_end, 0);

    // Small raster: frame counter bumps together with frame_start at (0,0).
    ph = 0; pv = 0; ple = 0;
    k = 0;
    while (if_s.frame_cnt != 16'd2 && k < 1000) begin
      ph = int'(if_s.hc); pv = int'(if_s.vc); ple = int'(if_s.line_end);
      step(1'b1);
      k++;
    end
    chk("reach_frame2", k < 1000, 1);
    chk("fc_frame_start", if_s.frame_start, 1);
    chk("fc_hc", if_s.hc, 0);
    chk("fc_vc", if_s.vc, 0);
    chk("prev_hc", ph, 29);
    chk("prev_vc", pv, 14);
    chk("prev_line_end", ple, 1);

    // One full small frame: vsync low for exactly two lines of 30 pixels.
    vs_low = 0;
    for (int i = 0; i < 450; i++) begin
      step(1'b1);
      if (if_s.vsync == 1'b0) vs_low++;
    end
    chk("vsync_low_cycles", vs_low, 60);

    // ce toggling: 60 steps contain 30 enabled edges, exactly one small line.
    h0 = int'(if_s.hc);
    v0 = int'(if_s.vc);
    for (int i = 0; i < 60; i++) step(i[0] ? 1'b0 : 1'b1);
    chk("toggle_hc", if_s.hc, h0);
    chk("toggle_vc", if_s.vc, (v0 + 1) % 15);
    for (int i = 0; i < 300; i++) step(i[0] ? 1'b1 : 1'b0);

    // Asynchronous reset mid-frame, observed before the next rising edge.
    k = 0;
    while (!(if_s.hc == 10'd10 && if_s.vc == 10'd5) && k < 500) begin
      step(1'b1);
      k++;
    end
    chk("reach_10_5", k < 500, 1);
    #5 rst = 1'b1;
    #1;
    chk("arst_hc", if_s.hc, 0);
    chk("arst_vc", if_s.vc, 0);
    chk("arst_valid", if_s.valid, 0);
    chk("arst_hsync", if_s.hsync, 1);
    chk("arst_frame_cnt", if_s.frame_cnt, 0);
    chk("arst_d_frame_cnt", if_d.frame_cnt, 0);
    compare_all();
    @(negedge clk_25m);
    rst = 1'b0;
    compare_all();
    step(1'b1);
    chk("restart_hc", if_s.hc, 0);
    chk("restart_valid", if_s.valid, 1);
    chk("restart_frame_start", if_s.frame_start, 1);
    chk("restart_frame_cnt", if_s.frame_cnt, 0);
    for (int i = 0; i < 500; i++) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end
endmodule
